// File: rtl/rns_pkg.sv
// Width helpers and rotation constants for the four-moduli RNS reverse converter
// over {2^N-1, 2^N+1, 2^(2N)+1, 2^(2N+P)}.
package rns_pkg;

  localparam int N_DEF  = 20;
  localparam int P_DEF  = 7;
  localparam int STAGES = 3;

  function automatic int k_width(input int n, input int p);
    return 2*n + p;
  endfunction

  function automatic int x_width(input int n, input int p);
    return 6*n + p + 1;
  endfunction

  function automatic bit p_legal(input int n, input int p);
    return (p >= 0) && (p <= n - 2);
  endfunction

  // (-k) mod m, used to turn 2^(-K) into a forward rotation
  function automatic int neg_mod(input int k, input int m);
    return (m - (k % m)) % m;
  endfunction

  // 2 has order N mod 2^N-1, 2N mod 2^N+1 and 4N mod 2^(2N)+1
  function automatic int rot_m1(input int n, input int p);
    return neg_mod(k_width(n, p), n);
  endfunction

  function automatic int rot_m2(input int n, input int p);
    return neg_mod(k_width(n, p), 2*n);
  endfunction

  function automatic int rot_m3(input int n, input int p);
    return neg_mod(k_width(n, p), 4*n);
  endfunction

endpackage

// File: rtl/rns_modsub.sv
// y = ((a - b) * 2^J) mod m, m = 2^KW-1 (PLUS=0) or 2^KW+1 (PLUS=1).
// Operands must already be reduced; purely combinational, no multipliers.
module rns_modsub #(
  parameter int KW   = 20,
  parameter bit PLUS = 1'b0,
  parameter int J    = 0,
  localparam int W   = PLUS ? KW + 1 : KW
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);

  if (!PLUS) begin : g_minus
    localparam int S = J % KW;
    logic [KW:0]     diff;
    logic [KW-1:0]   d;
    logic [2*KW-1:0] dd;

    // end-around borrow: a negative difference wraps by 2^KW, so take one more off
    assign diff = {1'b0, a} - {1'b0, b};
    assign d    = diff[KW] ? diff[KW-1:0] - KW'(1) : diff[KW-1:0];
    assign dd   = {d, d};
    assign y    = dd[2*KW-1-S -: KW];
  end else begin : g_plus
    localparam int S   = J % KW;
    localparam bit NEG = ((J / KW) % 2) == 1;
    localparam logic [KW:0] M = {1'b1, {(KW-1){1'b0}}, 1'b1};
    logic [KW+1:0] diff, t;
    logic [KW:0]   d, v;
    logic [2*KW:0] prod;

    assign diff = {1'b0, a} - {1'b0, b};
    assign d    = diff[KW+1] ? diff[KW:0] + M : diff[KW:0];
    // 2^KW == -1: the bits shifted past KW fold back subtracted
    assign prod = {{KW{1'b0}}, d} << S;
    assign t    = {2'b00, prod[KW-1:0]} - {1'b0, prod[2*KW:KW]};
    assign v    = t[KW+1] ? t[KW:0] + M : t[KW:0];
    assign y    = (NEG && v != '0) ? M - v : v;
  end

endmodule

// File: rtl/rns_converter.sv
// Three-stage CRT reverse converter, RNS tuple -> binary x in [0, M-1].
// Optional RNS_RANGE_CHECK_EN adds range_err for out-of-range r2/r3.
module rns_converter
  import rns_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int P = P_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [N-1:0]       r1,
  input  logic [N:0]         r2,
  input  logic [2*N:0]       r3,
  input  logic [2*N+P-1:0]   r4,
  output logic               out_valid,
  output logic [6*N+P:0]     x
`ifdef RNS_RANGE_CHECK_EN
  ,
  output logic               range_err
`endif
);

  localparam int K = k_width(N, P);
  localparam logic [N:0]   M2 = {1'b1, {(N-1){1'b0}}, 1'b1};
  localparam logic [2*N:0] M3 = {1'b1, {(2*N-1){1'b0}}, 1'b1};

  if (!p_legal(N, P)) begin : g_bad_p
    $error("rns_converter: P must satisfy 0 <= P <= N-2");
  end

  logic [STAGES:1] vld_pipe;

  // input normalisation: alternate zero for r1, single subtract for r2/r3
  logic [N-1:0]   n1;
  logic [N:0]     n2;
  logic [2*N:0]   n3;
  logic           err_in;
  assign n1     = (&r1) ? '0 : r1;
  assign n2     = (r2 >= M2) ? r2 - M2 : r2;
  assign n3     = (r3 >= M3) ? r3 - M3 : r3;
  assign err_in = (r2 >= M2) | (r3 >= M3);

  // r4 reduced into each modulus by folding N-bit chunks (at most three)
  logic [3*N-1:0] r4w;
  logic [N+1:0]   fs1;
  logic [N:0]     ff1;
  logic [N-1:0]   ff2, q1;
  logic [N+2:0]   t2;
  logic [N:0]     q2;
  logic [2*N+1:0] t3;
  logic [2*N:0]   q3;

  assign r4w = (3*N)'(r4);
  assign fs1 = (N+2)'(r4w[N-1:0]) + (N+2)'(r4w[2*N-1:N]) + (N+2)'(r4w[3*N-1:2*N]);
  assign ff1 = (N+1)'(fs1[N-1:0]) + (N+1)'(fs1[N+1:N]);
  assign ff2 = ff1[N-1:0] + N'(ff1[N]);
  assign q1  = (&ff2) ? '0 : ff2;

  assign t2 = (N+3)'(r4w[N-1:0]) + (N+3)'(r4w[3*N-1:2*N]) - (N+3)'(r4w[2*N-1:N]);
  assign q2 = t2[N+2]              ? (N+1)'(t2 + (N+3)'(M2)) :
              (t2 >= (N+3)'(M2))   ? (N+1)'(t2 - (N+3)'(M2)) : t2[N:0];

  assign t3 = (2*N+2)'(r4w[2*N-1:0]) - (2*N+2)'(r4w[3*N-1:2*N]);
  assign q3 = t3[2*N+1] ? (2*N+1)'(t3 + (2*N+2)'(M3)) : t3[2*N:0];

  // stage 1: y_i = (r_i - r4) * 2^-K mod m_i
  logic [N-1:0] y1;
  logic [N:0]   y2;
  logic [2*N:0] y3;

  rns_modsub #(.KW(N),   .PLUS(1'b0), .J(rot_m1(N, P))) u_s1_m1 (.a(n1), .b(q1), .y(y1));
  rns_modsub #(.KW(N),   .PLUS(1'b1), .J(rot_m2(N, P))) u_s1_m2 (.a(n2), .b(q2), .y(y2));
  rns_modsub #(.KW(2*N), .PLUS(1'b1), .J(rot_m3(N, P))) u_s1_m3 (.a(n3), .b(q3), .y(y3));

  logic [N-1:0]   s1_y1;
  logic [N:0]     s1_y2;
  logic [2*N:0]   s1_y3, s2_y3;
  logic [K-1:0]   s1_r4, s2_r4;
  logic [2*N-1:0] s2_y12;

  // stage 2: merge m1, m2 -> Y12 mod 2^(2N)-1; y2 first brought into [0, m1-1]
  logic [N-1:0]   y2r, t1;
  logic [2*N-1:0] y12;
  assign y2r = s1_y2[N] ? N'(1) : (&s1_y2[N-1:0]) ? '0 : s1_y2[N-1:0];

  rns_modsub #(.KW(N), .PLUS(1'b0), .J(N-1)) u_s2 (.a(s1_y1), .b(y2r), .y(t1));

  assign y12 = (2*N)'(s1_y2) + {t1, {N{1'b0}}} + (2*N)'(t1);

  // stage 3: merge with m3 -> Y mod 2^(4N)-1; the 2^(4N) carry wraps out harmlessly
  logic [2*N:0]   t3s;
  logic [4*N-1:0] y_full;

  rns_modsub #(.KW(2*N), .PLUS(1'b1), .J(2*N-1)) u_s3 (.a(s2_y3), .b({1'b0, s2_y12}), .y(t3s));

  assign y_full = (4*N)'(s2_y12) + {t3s[2*N-1:0], {(2*N){1'b0}}} - (4*N)'(t3s);

  always_ff @(posedge clk) begin
    s1_y1  <= y1;
    s1_y2  <= y2;
    s1_y3  <= y3;
    s1_r4  <= r4;
    s2_y12 <= y12;
    s2_y3  <= s1_y3;
    s2_r4  <= s1_r4;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      x        <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
      if (vld_pipe[STAGES-1]) x <= {1'b0, y_full, s2_r4};
    end
  end

  assign out_valid = vld_pipe[STAGES];

`ifdef RNS_RANGE_CHECK_EN
  logic s1_err, s2_err;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_err    <= 1'b0;
      s2_err    <= 1'b0;
      range_err <= 1'b0;
    end else begin
      s1_err <= err_in;
      s2_err <= s1_err;
      if (vld_pipe[STAGES-1]) range_err <= s2_err;
    end
  end
`else
  logic unused_err;
  assign unused_err = err_in;
`endif

endmodule

// File: tb/tb_rns_converter.sv
// Scoreboard bench for rns_converter (N=20, P=7): expected x pushed at drive time,
// popped and compared when out_valid rises three edges after sampling.
module tb_rns_converter;

  localparam int N  = 20;
  localparam int P  = 7;
  localparam int K  = 2*N + P;
  localparam int XW = 6*N + P + 1;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic [N-1:0]   r1 = '0;
  logic [N:0]     r2 = '0;
  logic [2*N:0]   r3 = '0;
  logic [K-1:0]   r4 = '0;
  logic           out_valid;
  logic [XW-1:0]  x;
`ifdef RNS_RANGE_CHECK_EN
  logic           range_err;
`endif

  typedef struct {
    logic [XW-1:0] x;
    logic          err;
    int            iter;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;
  logic [XW-1:0] mm, mm1, mm2, mm3;

  always #5 clk = ~clk;

  rns_converter #(.N(N), .P(P)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .r1        (r1),
    .r2        (r2),
    .r3        (r3),
    .r4        (r4),
    .out_valid (out_valid),
    .x         (x)
`ifdef RNS_RANGE_CHECK_EN
    ,
    .range_err (range_err)
`endif
  );

  function automatic logic [XW-1:0] rand_x();
    logic [XW-1:0] v;
    v = {$urandom(), $urandom(), $urandom(), $urandom()};
    return v % mm;
  endfunction

  // residues of v, optionally pushed above the modulus for r2/r3
  task automatic drive_tuple(input logic [XW-1:0] v, input bit oor, input int iter, input bit push);
    logic [XW-1:0] a2, a3;
    logic e;
    e  = 1'b0;
    a2 = v % mm2;
    a3 = v % mm3;
    if (oor && $urandom_range(0, 1) == 1 && a2 <= mm2 - 3) begin a2 = a2 + mm2; e = 1'b1; end
    if (oor && $urandom_range(0, 1) == 1 && a3 <= mm3 - 3) begin a3 = a3 + mm3; e = 1'b1; end
    r1 = N'(v % mm1);
    r2 = (N+1)'(a2);
    r3 = (2*N+1)'(a3);
    r4 = v[K-1:0];
    in_valid = 1'b1;
    if (push) q.push_back('{x: v, err: e, iter: iter});
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      drive_tuple(rand_x(), 1'b0, 0, 1'b0);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset out_valid got=%b exp=0", out_valid); end
    checks++;
    if (x !== '0) begin failures++; $display("FAIL reset x got=%h exp=0", x); end
`ifdef RNS_RANGE_CHECK_EN
    checks++;
    if (range_err !== 1'b0) begin failures++; $display("FAIL reset range_err got=%b exp=0", range_err); end
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL idle out_valid got=%b exp=0", out_valid); end
  endtask

  task automatic test_directed();
    logic [N-1:0]  v1 [6];
    logic [N:0]    v2 [6];
    logic [2*N:0]  v3 [6];
    logic [K-1:0]  v4 [6];
    logic [XW-1:0] vx [6];
    logic          ve [6];
    exp_t e;
    int lat;
    bit seen;
    v1 = '{20'd0, 20'd1, 20'd128, 20'd1048574, 20'hFFFFF, 20'd5};
    v2 = '{21'd0, 21'd1, 21'd128, 21'd1048576, 21'd0, 21'd1048582};
    v3 = '{41'd0, 41'd1, 41'd1099511627649, 41'd1099511627776, 41'd0, 41'd1099511627782};
    v4 = '{47'd0, 47'd1, 47'd0, 47'h7FFF_FFFF_FFFF, 47'd0, 47'd5};
    vx[0] = '0;
    vx[1] = XW'(1);
    vx[2] = XW'(1) << 47;
    vx[3] = mm - XW'(1);
    vx[4] = '0;
    vx[5] = XW'(5);
    ve = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      r1 = v1[i]; r2 = v2[i]; r3 = v3[i]; r4 = v4[i];
      in_valid = 1'b1;
      q.push_back('{x: vx[i], err: ve[i], iter: i});
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      seen = 1'b0;
      for (int c = 1; c <= 6 && !seen; c++) begin
        @(negedge clk);
        if (out_valid === 1'b1) begin seen = 1'b1; lat = c; end
      end
      e = q.pop_front();
      checks++;
      if (lat !== 3) begin failures++; $display("FAIL directed[%0d] latency got=%0d exp=3", i, lat); end
      checks++;
      if (x !== e.x) begin failures++; $display("FAIL directed[%0d] x got=%h exp=%h", i, x, e.x); end
`ifdef RNS_RANGE_CHECK_EN
      checks++;
      if (range_err !== e.err) begin failures++; $display("FAIL directed[%0d] range_err got=%b exp=%b", i, range_err, e.err); end
`endif
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || x !== e.x) begin
        failures++;
        $display("FAIL directed[%0d] hold out_valid=%b x=%h exp_x=%h", i, out_valid, x, e.x);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int got = 0;
    for (int k = 0; k < 110; k++) begin
      @(posedge clk); #1;
      if (k < 100) drive_tuple(rand_x(), $urandom_range(0, 3) == 0, k, 1'b1);
      else in_valid = 1'b0;
      @(negedge clk);
      if (q.size() > 0 && q[0].iter + 3 == k) begin
        e = q.pop_front();
        got++;
        checks++;
        if (out_valid !== 1'b1 || x !== e.x) begin
          failures++;
          $display("FAIL b2b iter=%0d out_valid=%b x=%h exp=%h", e.iter, out_valid, x, e.x);
        end
`ifdef RNS_RANGE_CHECK_EN
        checks++;
        if (range_err !== e.err) begin failures++; $display("FAIL b2b iter=%0d range_err got=%b exp=%b", e.iter, range_err, e.err); end
`endif
      end else begin
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b k=%0d out_valid got=%b exp=0", k, out_valid); end
      end
    end
    checks++;
    if (got !== 100 || q.size() != 0) begin
      failures++;
      $display("FAIL b2b count got=%0d exp=100 left=%0d", got, q.size());
    end
  endtask

  task automatic test_reset_midstream();
    exp_t e;
    for (int k = 0; k < 14; k++) begin
      @(posedge clk); #1;
      rst_n = (k == 5) ? 1'b0 : 1'b1;
      if (k == 6) while (q.size() > 0 && q[0].iter < 6) void'(q.pop_front());
      if (k < 10) drive_tuple(rand_x(), 1'b0, k, k != 5);
      else in_valid = 1'b0;
      @(negedge clk);
      if (k == 6) begin
        checks++;
        if (out_valid !== 1'b0 || x !== '0) begin
          failures++;
          $display("FAIL midrst flush out_valid=%b x=%h exp=0/0", out_valid, x);
        end
      end else if (q.size() > 0 && q[0].iter + 3 == k) begin
        e = q.pop_front();
        checks++;
        if (out_valid !== 1'b1 || x !== e.x) begin
          failures++;
          $display("FAIL midrst iter=%0d out_valid=%b x=%h exp=%h", e.iter, out_valid, x, e.x);
        end
      end else begin
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL midrst k=%0d stale out_valid=%b exp=0", k, out_valid); end
      end
    end
    checks++;
    if (q.size() != 0) begin failures++; $display("FAIL midrst leftover got=%0d exp=0", q.size()); end
  endtask

  initial begin
    mm1 = (XW'(1) << N) - XW'(1);
    mm2 = (XW'(1) << N) + XW'(1);
    mm3 = (XW'(1) << (2*N)) + XW'(1);
    mm  = ((XW'(1) << (4*N)) - XW'(1)) << K;
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
